// File: rtl/dac_fifo_arbiter.sv
// Round-robin scheduler sharing one byte-wide playback FIFO read port among DAC slots.
// Grants fixed-length read bursts and routes returned bytes back to the owning slot.
module dac_fifo_arbiter #(
   parameter int unsigned NUM_SLOTS    = 4,
   parameter int unsigned SLOT_BITS    = 2,
   parameter int unsigned ADDR_WIDTH   = 11,
   parameter int unsigned BURST_LEN    = 4,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   input  logic [NUM_SLOTS-1:0]            slot_req,
   output logic [NUM_SLOTS-1:0]            slot_grant,
   output logic [NUM_SLOTS-1:0]            slot_data_valid,
   output logic [7:0]                      slot_data,
   output logic [1:0]                      slot_byte_index,
   output logic                            fifo_read,
   output logic [SLOT_BITS-1:0]            fifo_slot,
   input  logic [7:0]                      fifo_data,
   input  logic [NUM_SLOTS*ADDR_WIDTH-1:0] fifo_addr_in,
   input  logic [NUM_SLOTS*ADDR_WIDTH-1:0] fifo_addr_out,
   output logic [NUM_SLOTS-1:0]            starved,
   input  logic                            starve_clear
);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e               state_q, state_d;
   logic [SLOT_BITS-1:0] cur_slot_q, cur_slot_d;
   logic [SLOT_BITS-1:0] last_grant_q, last_grant_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [NUM_SLOTS-1:0] grant_q, grant_d;
   logic [NUM_SLOTS-1:0] starved_q, starved_d;
   logic [NUM_SLOTS-1:0] eligible, short_req;
   logic [SLOT_BITS-1:0] rr_idx, pick_slot;
   logic                 pick_found;

   // Modular subtract absorbs pointer wrap.
   for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_occ
      logic [ADDR_WIDTH-1:0] occ;
      assign occ = fifo_addr_in[s*ADDR_WIDTH +: ADDR_WIDTH]
                 - fifo_addr_out[s*ADDR_WIDTH +: ADDR_WIDTH];
      assign eligible[s]  = slot_req[s] && (occ >= ADDR_WIDTH'(BURST_LEN));
      assign short_req[s] = slot_req[s] && (occ < ADDR_WIDTH'(BURST_LEN));
   end

   always_comb begin
      pick_found = 1'b0;
      pick_slot  = '0;
      rr_idx     = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         rr_idx = SLOT_BITS'((int'(last_grant_q) + 1 + i) % NUM_SLOTS);
         if (!pick_found && eligible[rr_idx]) begin
            pick_found = 1'b1;
            pick_slot  = rr_idx;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cur_slot_d   = cur_slot_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      grant_d      = '0;
      starved_d    = starved_q & ~{NUM_SLOTS{starve_clear}};
      case (state_q)
         StIdle: begin
            if (enable) begin
               starved_d = starved_d | short_req;
               if (pick_found) begin
                  state_d    = StBurst;
                  cur_slot_d = pick_slot;
                  cnt_d      = '0;
                  grant_d    = NUM_SLOTS'(1) << pick_slot;
               end
            end
         end
         StBurst: begin
            if (cnt_q == 2'(BURST_LEN - 1)) begin
               state_d      = StIdle;
               last_grant_d = cur_slot_q;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cur_slot_q   <= '0;
         last_grant_q <= SLOT_BITS'(NUM_SLOTS - 1);
         cnt_q        <= '0;
         grant_q      <= '0;
         starved_q    <= '0;
      end else begin
         state_q      <= state_d;
         cur_slot_q   <= cur_slot_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         starved_q    <= starved_d;
      end
   end

   assign fifo_read  = (state_q == StBurst);
   assign fifo_slot  = cur_slot_q;
   assign slot_grant = grant_q;
   assign starved    = starved_q;

   // Tag pipeline matches the FIFO read latency so each byte finds its owner.
   logic [READ_LATENCY-1:0] tag_valid_q;
   logic [SLOT_BITS-1:0]    tag_slot_q [READ_LATENCY];
   logic [1:0]              tag_idx_q  [READ_LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            tag_valid_q[i] <= 1'b0;
            tag_slot_q[i]  <= '0;
            tag_idx_q[i]   <= '0;
         end
      end else begin
         tag_valid_q[0] <= fifo_read;
         tag_slot_q[0]  <= cur_slot_q;
         tag_idx_q[0]   <= cnt_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            tag_valid_q[i] <= tag_valid_q[i-1];
            tag_slot_q[i]  <= tag_slot_q[i-1];
            tag_idx_q[i]   <= tag_idx_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_data_valid <= '0;
         slot_data       <= '0;
         slot_byte_index <= '0;
      end else if (tag_valid_q[READ_LATENCY-1]) begin
         slot_data_valid <= NUM_SLOTS'(1) << tag_slot_q[READ_LATENCY-1];
         slot_data       <= fifo_data;
         slot_byte_index <= tag_idx_q[READ_LATENCY-1];
      end else begin
         slot_data_valid <= '0;
      end
   end

endmodule

// File: tb/tb_dac_fifo_arbiter.sv
// Directed bench for dac_fifo_arbiter with a fixed-latency FIFO model.
// Stimulus and checks happen on the falling edge, away from the active edge.
module tb_dac_fifo_arbiter;

   localparam int NS = 4;
   localparam int SB = 2;
   localparam int AW = 11;
   localparam int BL = 4;
   localparam int RL = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [NS-1:0]     slot_req;
   logic [NS-1:0]     slot_grant;
   logic [NS-1:0]     slot_data_valid;
   logic [7:0]        slot_data;
   logic [1:0]        slot_byte_index;
   logic              fifo_read;
   logic [SB-1:0]     fifo_slot;
   logic [7:0]        fifo_data;
   logic [NS*AW-1:0]  fifo_addr_in;
   logic [NS*AW-1:0]  fifo_addr_out;
   logic [NS-1:0]     starved;
   logic              starve_clear;

   int vectors     = 0;
   int miscompares = 0;

   dac_fifo_arbiter #(
      .NUM_SLOTS   (NS),
      .SLOT_BITS   (SB),
      .ADDR_WIDTH  (AW),
      .BURST_LEN   (BL),
      .READ_LATENCY(RL)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .slot_req       (slot_req),
      .slot_grant     (slot_grant),
      .slot_data_valid(slot_data_valid),
      .slot_data      (slot_data),
      .slot_byte_index(slot_byte_index),
      .fifo_read      (fifo_read),
      .fifo_slot      (fifo_slot),
      .fifo_data      (fifo_data),
      .fifo_addr_in   (fifo_addr_in),
      .fifo_addr_out  (fifo_addr_out),
      .starved        (starved),
      .starve_clear   (starve_clear)
   );

   always #5 clk = ~clk;

   // FIFO model: slot s returns bytes {A+s, n} with n counting reads of that slot.
   logic [3:0] rd_cnt [NS];
   logic [7:0] m_byte [RL];
   logic       m_vld  [RL];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NS; i++) rd_cnt[i] <= 4'd0;
         for (int j = 0; j < RL; j++) begin
            m_vld[j]  <= 1'b0;
            m_byte[j] <= 8'h00;
         end
      end else begin
         m_vld[0]  <= fifo_read;
         m_byte[0] <= {4'hA + 4'(fifo_slot), rd_cnt[fifo_slot]};
         if (fifo_read) rd_cnt[fifo_slot] <= rd_cnt[fifo_slot] + 4'd1;
         for (int j = 1; j < RL; j++) begin
            m_vld[j]  <= m_vld[j-1];
            m_byte[j] <= m_byte[j-1];
         end
      end
   end

   assign fifo_data = m_vld[RL-1] ? m_byte[RL-1] : 8'h00;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_occ(input int s, input int n);
      fifo_addr_out[s*AW +: AW] = 11'd100;
      fifo_addr_in[s*AW +: AW]  = 11'(100 + n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset         = 1'b1;
      enable        = 1'b1;
      slot_req      = '0;
      starve_clear  = 1'b0;
      fifo_addr_in  = '0;
      fifo_addr_out = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (slot_grant !== 4'b0 || slot_data_valid !== 4'b0) begin
         miscompares++;
         $display("FAIL reset grant/valid got %b/%b want 0000/0000", slot_grant, slot_data_valid);
      end
      vectors++;
      if (slot_data !== 8'h00 || slot_byte_index !== 2'd0) begin
         miscompares++;
         $display("FAIL reset data/index got %h/%0d want 00/0", slot_data, slot_byte_index);
      end
      vectors++;
      if (fifo_read !== 1'b0 || fifo_slot !== 2'd0 || starved !== 4'b0) begin
         miscompares++;
         $display("FAIL reset read/slot/starved got %b/%0d/%b want 0/0/0000",
                  fifo_read, fifo_slot, starved);
      end
   endtask

   task automatic test_single();
      logic       exp_rd;
      logic [3:0] exp_gnt;
      logic [3:0] exp_vld;
      do_reset();
      set_occ(0, 16);
      slot_req = 4'b0001;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp_rd  = (k >= 1 && k <= 4);
         exp_gnt = (k == 1) ? 4'b0001 : 4'b0000;
         exp_vld = (k >= 4 && k <= 7) ? 4'b0001 : 4'b0000;
         vectors++;
         if (fifo_read !== exp_rd || slot_grant !== exp_gnt) begin
            miscompares++;
            $display("FAIL single read/grant k=%0d got %b/%b want %b/%b",
                     k, fifo_read, slot_grant, exp_rd, exp_gnt);
         end
         if (exp_rd) begin
            vectors++;
            if (fifo_slot !== 2'd0) begin
               miscompares++;
               $display("FAIL single fifo_slot k=%0d got %0d want 0", k, fifo_slot);
            end
         end
         vectors++;
         if (slot_data_valid !== exp_vld) begin
            miscompares++;
            $display("FAIL single valid k=%0d got %b want %b", k, slot_data_valid, exp_vld);
         end
         if (exp_vld != 4'b0) begin
            vectors++;
            if (slot_data !== 8'hA0 + 8'(k - 4) || slot_byte_index !== 2'(k - 4)) begin
               miscompares++;
               $display("FAIL single data k=%0d got %h/%0d want %h/%0d", k, slot_data,
                        slot_byte_index, 8'hA0 + 8'(k - 4), k - 4);
            end
         end
         if (k == 1) slot_req = 4'b0000;
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt;
      do_reset();
      for (int s = 0; s < NS; s++) set_occ(s, 8);
      slot_req = 4'b1111;
      for (int k = 1; k <= 22; k++) begin
         tick();
         exp_gnt = ((k - 1) % 5 == 0) ? (4'b0001 << (((k - 1) / 5) % 4)) : 4'b0000;
         vectors++;
         if (slot_grant !== exp_gnt) begin
            miscompares++;
            $display("FAIL rr grant k=%0d got %b want %b", k, slot_grant, exp_gnt);
         end
         if ((k - 1) % 5 == 0) begin
            vectors++;
            if (fifo_slot !== 2'(((k - 1) / 5) % 4) || fifo_read !== 1'b1) begin
               miscompares++;
               $display("FAIL rr fifo_slot k=%0d got %0d/%b want %0d/1", k, fifo_slot,
                        fifo_read, ((k - 1) / 5) % 4);
            end
         end
      end
      slot_req = 4'b0000;
      for (int k = 0; k < 8; k++) tick();
   endtask

   task automatic test_starve();
      do_reset();
      set_occ(1, 3);
      set_occ(2, 8);
      slot_req = 4'b0110;
      tick();
      vectors++;
      if (slot_grant !== 4'b0100 || fifo_slot !== 2'd2) begin
         miscompares++;
         $display("FAIL starve grant got %b/%0d want 0100/2", slot_grant, fifo_slot);
      end
      vectors++;
      if (starved !== 4'b0010) begin
         miscompares++;
         $display("FAIL starve set got %b want 0010", starved);
      end
      slot_req = 4'b0010;
      for (int k = 0; k < 5; k++) tick();
      vectors++;
      if (fifo_read !== 1'b0 || slot_grant !== 4'b0000) begin
         miscompares++;
         $display("FAIL starve no grant got %b/%b want 0/0000", fifo_read, slot_grant);
      end
      slot_req     = 4'b0000;
      starve_clear = 1'b1;
      tick();
      vectors++;
      if (starved !== 4'b0000) begin
         miscompares++;
         $display("FAIL starve clear got %b want 0000", starved);
      end
      slot_req = 4'b0010;
      tick();
      vectors++;
      if (starved !== 4'b0010) begin
         miscompares++;
         $display("FAIL starve set-wins got %b want 0010", starved);
      end
      slot_req     = 4'b0000;
      starve_clear = 1'b1;
      tick();
      starve_clear = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      fifo_addr_in[0 +: AW]  = 11'd2;
      fifo_addr_out[0 +: AW] = 11'd2046;
      slot_req = 4'b0001;
      tick();
      vectors++;
      if (slot_grant !== 4'b0001 || fifo_read !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap occ4 grant got %b/%b want 0001/1", slot_grant, fifo_read);
      end
      slot_req = 4'b0000;
      for (int k = 0; k < 4; k++) tick();
      fifo_addr_in[0 +: AW] = 11'd1;
      slot_req = 4'b0001;
      tick();
      vectors++;
      if (slot_grant !== 4'b0000 || fifo_read !== 1'b0 || starved !== 4'b0001) begin
         miscompares++;
         $display("FAIL wrap occ3 grant/read/starved got %b/%b/%b want 0000/0/0001",
                  slot_grant, fifo_read, starved);
      end
      slot_req = 4'b0000;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      set_occ(0, 16);
      set_occ(1, 16);
      slot_req = 4'b0001;
      tick();
      slot_req = 4'b0000;
      for (int k = 0; k < 4; k++) tick();
      slot_req = 4'b0010;
      tick();
      vectors++;
      if (slot_grant !== 4'b0010) begin
         miscompares++;
         $display("FAIL rstmid pre grant got %b want 0010", slot_grant);
      end
      tick();
      reset    = 1'b1;
      slot_req = 4'b0000;
      tick();
      vectors++;
      if (fifo_read !== 1'b0 || slot_grant !== 4'b0 || fifo_slot !== 2'd0 ||
          slot_data_valid !== 4'b0 || slot_data !== 8'h00 || slot_byte_index !== 2'd0) begin
         miscompares++;
         $display("FAIL rstmid outputs got rd=%b g=%b fs=%0d v=%b d=%h i=%0d want all zero",
                  fifo_read, slot_grant, fifo_slot, slot_data_valid, slot_data,
                  slot_byte_index);
      end
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         vectors++;
         if (slot_data_valid !== 4'b0000 || fifo_read !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid discard k=%0d got valid=%b read=%b want 0000/0",
                     k, slot_data_valid, fifo_read);
         end
      end
      slot_req = 4'b0011;
      tick();
      vectors++;
      if (slot_grant !== 4'b0001) begin
         miscompares++;
         $display("FAIL rstmid priority got %b want 0001", slot_grant);
      end
      slot_req = 4'b0000;
      for (int k = 0; k < 8; k++) tick();
   endtask

   task automatic test_enable();
      do_reset();
      for (int s = 0; s < NS; s++) set_occ(s, 8);
      enable   = 1'b0;
      slot_req = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         tick();
         vectors++;
         if (fifo_read !== 1'b0 || slot_grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL enable gated k=%0d got %b/%b want 0/0000", k, fifo_read, slot_grant);
         end
      end
      enable = 1'b1;
      tick();
      vectors++;
      if (slot_grant !== 4'b0001 || fifo_read !== 1'b1) begin
         miscompares++;
         $display("FAIL enable start got %b/%b want 0001/1", slot_grant, fifo_read);
      end
      enable = 1'b0;
      for (int k = 2; k <= 9; k++) begin
         tick();
         vectors++;
         if (fifo_read !== (k <= 4) || slot_grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL enable midburst k=%0d got %b/%b want %b/0000", k, fifo_read,
                     slot_grant, (k <= 4));
         end
      end
      slot_req = 4'b0000;
      enable   = 1'b1;
   endtask

   initial begin
      reset         = 1'b1;
      enable        = 1'b1;
      slot_req      = '0;
      starve_clear  = 1'b0;
      fifo_addr_in  = '0;
      fifo_addr_out = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_starve();
      test_wrap();
      test_reset_mid_burst();
      test_enable();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dac_fifo_arbiter.md
# dac_fifo_arbiter

Round-robin scheduler that shares one byte-wide playback FIFO read port among several DAC slot modules. It grants each requesting slot a fixed-length burst of consecutive FIFO reads (one audio sample word, LSB byte first), but only when that slot's FIFO region holds enough data. It tracks the fixed FIFO read latency and routes returned bytes to the owning slot with a byte index. It sits between the per-slot FIFO pointer logic and the slot DAC modules, replacing per-slot direct FIFO reads.

## Interface
Parameters:
- NUM_SLOTS, 4: number of requesting slots
- SLOT_BITS, 2: width of slot index, log2(NUM_SLOTS)
- ADDR_WIDTH, 11: FIFO pointer width per slot
- BURST_LEN, 4: bytes read per grant; must be 2..4
- READ_LATENCY, 2: cycles from fifo_read high to valid fifo_data; must be ≥1

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  when low, no new burst starts; an in-progress burst completes
- slot_req  in  NUM_SLOTS  level request per slot; one burst per grant
- slot_grant  out  NUM_SLOTS  one-hot, 1-cycle pulse on the first read cycle of a burst
- slot_data_valid  out  NUM_SLOTS  one-hot strobe; slot_data belongs to this slot
- slot_data  out  8  returned FIFO byte
- slot_byte_index  out  2  byte position within burst, 0 = LSB
- fifo_read  out  1  read strobe, one byte per cycle
- fifo_slot  out  SLOT_BITS  slot region addressed by fifo_read
- fifo_data  in  8  FIFO read data, READ_LATENCY cycles after fifo_read
- fifo_addr_in  in  NUM_SLOTS*ADDR_WIDTH  per-slot write pointers, packed, slot 0 in LSBs
- fifo_addr_out  in  NUM_SLOTS*ADDR_WIDTH  per-slot read pointers, packed
- starved  out  NUM_SLOTS  sticky: slot requested while its data was insufficient
- starve_clear  in  1  clears all starved bits

## Operation
- occupancy[s] = (fifo_addr_in[s] − fifo_addr_out[s]) mod 2^ADDR_WIDTH. Pointer wrap is handled by the modular subtract. Slot s is eligible when slot_req[s]=1 and occupancy[s] ≥ BURST_LEN.
- FSM states: IDLE and BURST.
  - IDLE: if enable=1 and any slot is eligible, select the first eligible slot in round-robin order starting at last_grant+1 (mod NUM_SLOTS). Store it as cur_slot, then go to BURST. Otherwise stay in IDLE.
  - BURST: fifo_read=1 and fifo_slot=cur_slot for BURST_LEN consecutive cycles. The read counter runs 0..BURST_LEN−1. At count BURST_LEN−1, set last_grant←cur_slot and return to IDLE.
- slot_grant[cur_slot]=1 only in the first BURST cycle. A requester that wants one burst drops slot_req on seeing the grant. A request still high in the next IDLE evaluation is considered again.
- Arbitration occurs only in IDLE cycles. Each burst costs BURST_LEN+1 cycles.
- Return pipeline: shift register of depth READ_LATENCY carrying {valid, slot, byte index}, loaded on every fifo_read cycle. When a valid tag emerges, register slot_data←fifo_data, slot_byte_index←tag index, and slot_data_valid←one-hot(tag slot). All three outputs are valid for one cycle. The pipeline runs regardless of FSM state or enable.
- starved[s] sets in an IDLE cycle with enable=1 when slot_req[s]=1 and occupancy[s] < BURST_LEN. starve_clear clears all bits. If set and clear occur in the same cycle, set wins for that slot.
- Reset, including mid-burst: state←IDLE, last_grant←NUM_SLOTS−1 (so slot 0 has first priority), counter←0, return pipeline emptied. In-flight bytes are discarded.

## Timing
- Reset values: slot_grant=0, slot_data_valid=0, slot_data=0, slot_byte_index=0, fifo_read=0, fifo_slot=0, starved=0.
- All outputs are registered.
- Eligible request seen in IDLE at cycle T: fifo_read and slot_grant are high from cycle T+1; fifo_read stays high through T+BURST_LEN.
- The earliest next arbitration is cycle T+BURST_LEN+1.
- Byte k of a burst is read at cycle T+1+k and appears on slot_data/slot_data_valid at cycle T+1+k+READ_LATENCY+1.
- enable falling mid-burst: the burst completes. enable is sampled only in IDLE.
- A slot_req drop mid-burst has no effect on the current burst.

## Test plan
- Single slot: slot_req=0001, occupancy[0]=16, T=IDLE cycle → fifo_read high T+1..T+4 with fifo_slot=0, grant pulse 0001 at T+1. Bytes A0,A1,A2,A3 delivered at T+4..T+7 with index 0..3 and valid=0001.
- Round-robin: slot_req=1111 held, all occupancy ≥4, from reset → grants in order 0,1,2,3,0 at 5-cycle spacing.
- Insufficient data: slot_req=0110, occupancy[1]=3, occupancy[2]=8 → only slot 2 granted and starved=0010. After starve_clear → starved=0000. Simultaneous starve_clear and a new underflow → bit remains 1.
- Pointer wrap: fifo_addr_in[0]=2, fifo_addr_out[0]=2046 → occupancy 4, slot 0 granted. fifo_addr_in=1 with the same read pointer → occupancy 3, no grant.
- Reset mid-burst: assert reset during the 2nd read cycle → next cycle fifo_read=0 and all outputs at reset values. No slot_data_valid from discarded reads. After release, slot 0 has first priority.
- enable gating: enable=0 with eligible requests → no fifo_read. enable dropped during a burst → all 4 reads complete, no further grant.
